// File: rtl/seq_pattern_tx_if.sv
// Control/data bundle for the serial pattern transmitter.
// The master drives the run controls; the slave (the transmitter) drives the serial line and status.
interface seq_pattern_tx_if #(
  parameter int WIDTH = 4,
  parameter int REP_W = 4
);
  logic             start;
  logic             stop;
  logic [WIDTH-1:0] pat;
  logic [REP_W-1:0] reps;
  logic             dout;
  logic             dout_valid;
  logic             busy;
  logic             done;
  logic [1:0]       current;

  modport master (
    output start, stop, pat, reps,
    input  dout, dout_valid, busy, done, current
  );

  modport slave (
    input  start, stop, pat, reps,
    output dout, dout_valid, busy, done, current
  );
endinterface

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: shifts a latched WIDTH-bit pattern out MSB first,
// repeating it reps times (0 = until stop) with GAP_LEN idle bits between repetitions.
module seq_pattern_tx #(
  parameter int WIDTH   = 4,
  parameter int REP_W   = 4,
  parameter int GAP_LEN = 2
) (
  input  logic            clk,
  input  logic            rst,
  seq_pattern_tx_if.slave bus
);
  localparam int BIT_W = $clog2(WIDTH);
  localparam int GAP_W = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;

  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
  localparam logic [REP_W-1:0] REP_ONE  = REP_W'(1);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
  localparam logic [GAP_W-1:0] GAP_LAST = (GAP_LEN > 0) ? GAP_W'(GAP_LEN - 1) : '0;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SEND = 2'b01,
    GAP  = 2'b10,
    DONE = 2'b11
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] pat_reg, pat_next;
  logic [WIDTH-1:0] shreg_reg, shreg_next;
  logic [BIT_W-1:0] bit_cnt_reg, bit_cnt_next;
  logic [REP_W-1:0] rep_cnt_reg, rep_cnt_next;
  logic [GAP_W-1:0] gap_cnt_reg, gap_cnt_next;
  logic             stop_reg, stop_next;
  logic             dout_reg, dout_valid_reg, busy_reg, done_reg;

  always_comb begin
    state_next   = state_reg;
    pat_next     = pat_reg;
    shreg_next   = shreg_reg;
    bit_cnt_next = bit_cnt_reg;
    rep_cnt_next = rep_cnt_reg;
    gap_cnt_next = gap_cnt_reg;
    stop_next    = stop_reg;
    unique case (state_reg)
      IDLE: begin
        if (bus.start) begin
          pat_next     = bus.pat;
          shreg_next   = bus.pat;
          rep_cnt_next = bus.reps;
          bit_cnt_next = BIT_LAST;
          stop_next    = 1'b0;
          state_next   = SEND;
        end
      end
      SEND: begin
        shreg_next   = {shreg_reg[WIDTH-2:0], 1'b0};
        bit_cnt_next = bit_cnt_reg - BIT_ONE;
        if (bus.stop) stop_next = 1'b1;
        if (bit_cnt_reg == '0) begin
          // A live stop on the final bit ends the run just like a latched one.
          if (stop_reg || bus.stop || (rep_cnt_reg == REP_ONE)) begin
            state_next = DONE;
          end else begin
            if (rep_cnt_reg != '0) rep_cnt_next = rep_cnt_reg - REP_ONE;
            if (GAP_LEN > 0) begin
              state_next   = GAP;
              gap_cnt_next = GAP_LAST;
            end else begin
              shreg_next   = pat_reg;
              bit_cnt_next = BIT_LAST;
            end
          end
        end
      end
      GAP: begin
        gap_cnt_next = gap_cnt_reg - GAP_ONE;
        if (bus.stop) stop_next = 1'b1;
        if (gap_cnt_reg == '0) begin
          shreg_next   = pat_reg;
          bit_cnt_next = BIT_LAST;
          state_next   = SEND;
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered from the next-state values so they line up with state_reg.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      pat_reg        <= '0;
      shreg_reg      <= '0;
      bit_cnt_reg    <= '0;
      rep_cnt_reg    <= '0;
      gap_cnt_reg    <= '0;
      stop_reg       <= 1'b0;
      dout_reg       <= 1'b0;
      dout_valid_reg <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      pat_reg        <= pat_next;
      shreg_reg      <= shreg_next;
      bit_cnt_reg    <= bit_cnt_next;
      rep_cnt_reg    <= rep_cnt_next;
      gap_cnt_reg    <= gap_cnt_next;
      stop_reg       <= stop_next;
      dout_reg       <= (state_next == SEND) ? shreg_next[WIDTH-1] : 1'b0;
      dout_valid_reg <= (state_next == SEND);
      busy_reg       <= (state_next == SEND) || (state_next == GAP);
      done_reg       <= (state_next == DONE);
    end
  end

  assign bus.dout       = dout_reg;
  assign bus.dout_valid = dout_valid_reg;
  assign bus.busy       = busy_reg;
  assign bus.done       = done_reg;
  assign bus.current    = state_reg;
endmodule

// File: tb/tb_seq_pattern_tx.sv
// Scoreboard bench for seq_pattern_tx: one instance with a 2-bit gap, one back-to-back.
// Expected per-cycle observations are queued from hand-written strings and checked by a monitor.
module tb_seq_pattern_tx;
  typedef struct packed {
    logic       valid;
    logic       dout;
    logic       busy;
    logic       done;
    logic [1:0] cur;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   mon_on = 1'b0;
  int   compared = 0;
  int   mismatched = 0;
  int   det_a = 0;
  int   det_b = 0;
  logic [3:0] hist_a = '0;
  logic [3:0] hist_b = '0;
  string cur_test = "reset";
  obs_t  qa[$];
  obs_t  qb[$];

  always #5 clk = ~clk;

  seq_pattern_tx_if #(.WIDTH(4), .REP_W(4)) ifa ();
  seq_pattern_tx_if #(.WIDTH(4), .REP_W(4)) ifb ();

  seq_pattern_tx #(.WIDTH(4), .REP_W(4), .GAP_LEN(2)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa.slave)
  );
  seq_pattern_tx #(.WIDTH(4), .REP_W(4), .GAP_LEN(0)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb.slave)
  );

  // '1'/'0' = valid pattern bit, 'g' = gap cycle, 'D' = done pulse, 'i' = idle.
  function automatic obs_t decode(input byte c);
    case (c)
      "0":     return 6'b1_0_1_0_01;
      "1":     return 6'b1_1_1_0_01;
      "g":     return 6'b0_0_1_0_10;
      "D":     return 6'b0_0_0_1_11;
      default: return 6'b0_0_0_0_00;
    endcase
  endfunction

  always @(negedge clk) begin
    obs_t act, exp;
    if (mon_on) begin
      act = {ifa.dout_valid, ifa.dout, ifa.busy, ifa.done, ifa.current};
      exp = (qa.size() > 0) ? qa.pop_front() : obs_t'(6'b0);
      compared++;
      if (act !== exp) begin
        mismatched++;
        $display("FAIL %s dut_a t=%0t: got v=%b d=%b busy=%b done=%b cur=%b, required v=%b d=%b busy=%b done=%b cur=%b",
                 cur_test, $time, act.valid, act.dout, act.busy, act.done, act.cur,
                 exp.valid, exp.dout, exp.busy, exp.done, exp.cur);
      end
      if (act.valid) begin
        hist_a = {hist_a[2:0], act.dout};
        if (hist_a == 4'b1011) det_a++;
      end
      act = {ifb.dout_valid, ifb.dout, ifb.busy, ifb.done, ifb.current};
      exp = (qb.size() > 0) ? qb.pop_front() : obs_t'(6'b0);
      compared++;
      if (act !== exp) begin
        mismatched++;
        $display("FAIL %s dut_b t=%0t: got v=%b d=%b busy=%b done=%b cur=%b, required v=%b d=%b busy=%b done=%b cur=%b",
                 cur_test, $time, act.valid, act.dout, act.busy, act.done, act.cur,
                 exp.valid, exp.dout, exp.busy, exp.done, exp.cur);
      end
      if (act.valid) begin
        hist_b = {hist_b[2:0], act.dout};
        if (hist_b == 4'b1011) det_b++;
      end
    end
  end

  task automatic push_exp(input int which, input string s);
    for (int i = 0; i < s.len(); i++) begin
      if (which == 0) qa.push_back(decode(s[i]));
      else            qb.push_back(decode(s[i]));
    end
  endtask

  // Cycle 0 (idle) is the first expected entry; start is sampled at the following edge.
  task automatic launch(input int which, input string name, input logic [3:0] p,
                        input logic [3:0] r, input string s);
    @(posedge clk); #1;
    cur_test = name;
    if (which == 0) begin ifa.start = 1'b1; ifa.pat = p; ifa.reps = r; end
    else            begin ifb.start = 1'b1; ifb.pat = p; ifb.reps = r; end
    push_exp(which, s);
    @(posedge clk); #1;
    ifa.start = 1'b0;
    ifb.start = 1'b0;
  endtask

  task automatic drain(input int budget);
    for (int c = 0; c < budget && (qa.size() > 0 || qb.size() > 0); c++) @(posedge clk);
    if (qa.size() > 0 || qb.size() > 0) begin
      mismatched++;
      $display("FAIL %s drain: %0d/%0d entries left, required 0", cur_test, qa.size(), qb.size());
      qa.delete();
      qb.delete();
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic check_det(input string name, input int got, input int req);
    compared++;
    if (got != req) begin
      mismatched++;
      $display("FAIL %s detections: got %0d, required %0d", name, got, req);
    end
    $display("%s: detections %0d (required %0d)", name, got, req);
  endtask

  initial begin
    int d0;
    string s;
    ifa.start = 1'b0; ifa.stop = 1'b0; ifa.pat = '0; ifa.reps = '0;
    ifb.start = 1'b0; ifb.stop = 1'b0; ifb.pat = '0; ifb.reps = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    mon_on = 1'b1;
    repeat (3) @(posedge clk);
    $display("reset: outputs checked idle");

    d0 = det_a;
    launch(0, "basic", 4'b1011, 4'd2, "i1011gg1011Di");
    drain(100);
    check_det("basic", det_a - d0, 2);

    d0 = det_b;
    launch(1, "back_to_back", 4'b1011, 4'd3, "i101110111011Di");
    drain(100);
    check_det("back_to_back", det_b - d0, 3);

    launch(0, "single_rep", 4'b1011, 4'd1, "i1011Di");
    drain(100);
    $display("single_rep: done");

    s = "i";
    for (int k = 0; k < 4; k++) s = {s, "1100gg"};
    s = {s, "1100Di"};
    launch(0, "continuous_stop", 4'b1100, 4'd0, s);
    repeat (25) @(posedge clk);
    #1 ifa.stop = 1'b1;
    @(posedge clk); #1 ifa.stop = 1'b0;
    drain(100);
    $display("continuous_stop: done");

    launch(1, "stop_last_bit", 4'b1100, 4'd0, "i11001100Di");
    repeat (7) @(posedge clk);
    #1 ifb.stop = 1'b1;
    @(posedge clk); #1 ifb.stop = 1'b0;
    drain(100);
    $display("stop_last_bit: done");

    cur_test = "stop_in_idle";
    @(posedge clk); #1 ifa.stop = 1'b1;
    @(posedge clk); #1 ifa.stop = 1'b0;
    launch(0, "ignored_inputs", 4'b1011, 4'd2, "i1011gg1011Di");
    @(posedge clk); #1 ifa.start = 1'b1;
    @(posedge clk); #1 begin ifa.start = 1'b0; ifa.pat = 4'b0000; ifa.reps = 4'd1; end
    drain(100);
    $display("ignored_inputs: done");

    launch(0, "reset_mid_run", 4'b1011, 4'd4, "i1011gi");
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    drain(100);
    launch(0, "restart_after_reset", 4'b1001, 4'd1, "i1001Di");
    drain(100);
    $display("reset_mid_run: done");

    mon_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
